// File: rtl/bmp280_pkg.sv
// Shared register map and FSM encoding for the BMP280 SPI responder.
package bmp280_pkg;

   localparam logic [6:0] CALIB_T1_LSB   = 7'h08;
   localparam logic [6:0] CALIB_T1_MSB   = 7'h09;
   localparam logic [6:0] CALIB_T2_LSB   = 7'h0A;
   localparam logic [6:0] CALIB_T2_MSB   = 7'h0B;
   localparam logic [6:0] CALIB_T3_LSB   = 7'h0C;
   localparam logic [6:0] CALIB_T3_MSB   = 7'h0D;
   localparam logic [6:0] CHIP_ID_ADDR   = 7'h50;
   localparam logic [6:0] RESET_ADDR     = 7'h60;
   localparam logic [6:0] CTRL_MEAS_ADDR = 7'h74;
   localparam logic [6:0] CONFIG_ADDR    = 7'h75;
   localparam logic [6:0] TEMP_MSB_ADDR  = 7'h7A;
   localparam logic [6:0] TEMP_LSB_ADDR  = 7'h7B;
   localparam logic [6:0] TEMP_XLSB_ADDR = 7'h7C;

   localparam logic [7:0] SOFT_RESET_VAL = 8'hB6;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CTRL = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_RD   = 2'd3;

endpackage

// File: rtl/bmp280_spi_responder_spi_sync_edge.sv
// Synchronizes the SPI pins into clk and flags sclk/cs_n edges; mosi is delayed to match.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk_i,
   input  logic cs_n_i,
   input  logic mosi_i,
   output logic sclk_rise_o,
   output logic sclk_fall_o,
   output logic cs_fall_o,
   output logic cs_rise_o,
   output logic cs_n_s_o,
   output logic mosi_s_o
);

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_prev_q;
   logic                   cs_prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_rise_o = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
   assign sclk_fall_o = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
   assign cs_fall_o   = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
   assign cs_rise_o   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
   assign cs_n_s_o    = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s_o    = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bmp280_spi_responder.sv
// BMP280-style SPI mode-0 register responder with snapshot-consistent burst reads.
// Optional BMP_SOFT_RESET_EN: writing 0xB6 to 0x60 clears ctrl_meas and config_reg.
module bmp280_spi_responder
   import bmp280_pkg::*;
#(
   parameter int         DATA_WIDTH_SPI = 8,
   parameter logic [7:0] CHIP_ID        = 8'h58,
   parameter int         SYNC_STAGES    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sclk,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   input  logic [19:0] raw_temp,
   input  logic [15:0] dig_t1,
   input  logic [15:0] dig_t2,
   input  logic [15:0] dig_t3,
   output logic [7:0]  ctrl_meas,
   output logic [7:0]  config_reg,
   output logic        reg_wr_stb,
   output logic [6:0]  reg_wr_addr,
   output logic        busy
);

   logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_n_s, mosi_s;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .sclk_i     (sclk),
      .cs_n_i     (cs_n),
      .mosi_i     (mosi),
      .sclk_rise_o(sclk_rise),
      .sclk_fall_o(sclk_fall),
      .cs_fall_o  (cs_fall),
      .cs_rise_o  (cs_rise),
      .cs_n_s_o   (cs_n_s),
      .mosi_s_o   (mosi_s)
   );

   logic [1:0]                state_q, state_d;
   logic [2:0]                bitcnt_q, bitcnt_d;
   logic                      miso_q, miso_d;
   logic                      oe_q, oe_d;
   logic [7:0]                ctrl_q, ctrl_d;
   logic [7:0]                cfg_q, cfg_d;
   logic                      stb_q, stb_d;
   logic [6:0]                wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH_SPI-2:0] rx_q, rx_d;
   logic [DATA_WIDTH_SPI-1:0] tx_q, tx_d;
   logic [6:0]                addr_q, addr_d;
   logic [19:0]               temp_sh_q, temp_sh_d;
   logic [15:0]               t1_sh_q, t1_sh_d, t2_sh_q, t2_sh_d, t3_sh_q, t3_sh_d;
   logic [DATA_WIDTH_SPI-1:0] byte_in;
`ifdef BMP_SOFT_RESET_EN
   logic                      soft_pend_q, soft_pend_d;
`endif

   assign byte_in = {rx_q, mosi_s};

   function automatic logic [7:0] rd_byte(input logic [6:0] a, input logic [19:0] t,
                                          input logic [15:0] c1, input logic [15:0] c2,
                                          input logic [15:0] c3, input logic [7:0] cm,
                                          input logic [7:0] cf);
      logic [7:0] r;
      r = 8'h00;
      case (a)
         CALIB_T1_LSB:   r = c1[7:0];
         CALIB_T1_MSB:   r = c1[15:8];
         CALIB_T2_LSB:   r = c2[7:0];
         CALIB_T2_MSB:   r = c2[15:8];
         CALIB_T3_LSB:   r = c3[7:0];
         CALIB_T3_MSB:   r = c3[15:8];
         CHIP_ID_ADDR:   r = CHIP_ID;
         CTRL_MEAS_ADDR: r = cm;
         CONFIG_ADDR:    r = cf;
         TEMP_MSB_ADDR:  r = t[19:12];
         TEMP_LSB_ADDR:  r = t[11:4];
         TEMP_XLSB_ADDR: r = {t[3:0], 4'h0};
         default:        r = 8'h00;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      miso_d    = miso_q;
      oe_d      = oe_q;
      ctrl_d    = ctrl_q;
      cfg_d     = cfg_q;
      stb_d     = 1'b0;
      wr_addr_d = wr_addr_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      addr_d    = addr_q;
      temp_sh_d = temp_sh_q;
      t1_sh_d   = t1_sh_q;
      t2_sh_d   = t2_sh_q;
      t3_sh_d   = t3_sh_q;
`ifdef BMP_SOFT_RESET_EN
      soft_pend_d = 1'b0;
      if (soft_pend_q) begin
         ctrl_d = 8'h00;
         cfg_d  = 8'h00;
      end
`endif
      // cs_n release outranks any sclk edge in the same clk, so a closing byte is dropped
      if (cs_rise) begin
         state_d  = ST_IDLE;
         oe_d     = 1'b0;
         miso_d   = 1'b0;
         bitcnt_d = 3'd0;
      end else if (state_q == ST_IDLE) begin
         if (cs_fall) begin
            state_d  = ST_CTRL;
            bitcnt_d = 3'd0;
         end
      end else begin
         if (sclk_fall && state_q == ST_RD) begin
            miso_d = tx_q[DATA_WIDTH_SPI-1];
            tx_d   = {tx_q[DATA_WIDTH_SPI-2:0], 1'b0};
         end
         if (sclk_rise) begin
            rx_d     = byte_in[DATA_WIDTH_SPI-2:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
               case (state_q)
                  ST_CTRL: begin
                     addr_d = byte_in[6:0];
                     if (byte_in[7]) begin
                        temp_sh_d = raw_temp;
                        t1_sh_d   = dig_t1;
                        t2_sh_d   = dig_t2;
                        t3_sh_d   = dig_t3;
                        tx_d      = rd_byte(byte_in[6:0], raw_temp, dig_t1, dig_t2, dig_t3,
                                            ctrl_q, cfg_q);
                        oe_d      = 1'b1;
                        state_d   = ST_RD;
                     end else begin
                        state_d = ST_WR;
                     end
                  end
                  ST_WR: begin
                     state_d = ST_CTRL;
                     if (addr_q == CTRL_MEAS_ADDR) begin
                        ctrl_d    = byte_in;
                        stb_d     = 1'b1;
                        wr_addr_d = addr_q;
                     end else if (addr_q == CONFIG_ADDR) begin
                        cfg_d     = {byte_in[7:2], 1'b0, byte_in[0]};
                        stb_d     = 1'b1;
                        wr_addr_d = addr_q;
                     end
`ifdef BMP_SOFT_RESET_EN
                     else if (addr_q == RESET_ADDR && byte_in == SOFT_RESET_VAL) begin
                        soft_pend_d = 1'b1;
                        stb_d       = 1'b1;
                        wr_addr_d   = RESET_ADDR;
                     end
`endif
                  end
                  default: begin
                     addr_d = addr_q + 7'd1;
                     tx_d   = rd_byte(addr_q + 7'd1, temp_sh_q, t1_sh_q, t2_sh_q, t3_sh_q,
                                      ctrl_q, cfg_q);
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bitcnt_q  <= 3'd0;
         miso_q    <= 1'b0;
         oe_q      <= 1'b0;
         ctrl_q    <= 8'h00;
         cfg_q     <= 8'h00;
         stb_q     <= 1'b0;
         wr_addr_q <= 7'h00;
`ifdef BMP_SOFT_RESET_EN
         soft_pend_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bitcnt_q  <= bitcnt_d;
         miso_q    <= miso_d;
         oe_q      <= oe_d;
         ctrl_q    <= ctrl_d;
         cfg_q     <= cfg_d;
         stb_q     <= stb_d;
         wr_addr_q <= wr_addr_d;
`ifdef BMP_SOFT_RESET_EN
         soft_pend_q <= soft_pend_d;
`endif
      end
   end

   // Shift and shadow data registers are only consumed after being loaded in a transaction
   always_ff @(posedge clk) begin
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      temp_sh_q <= temp_sh_d;
      t1_sh_q   <= t1_sh_d;
      t2_sh_q   <= t2_sh_d;
      t3_sh_q   <= t3_sh_d;
   end

   assign miso        = miso_q;
   assign miso_oe     = oe_q;
   assign ctrl_meas   = ctrl_q;
   assign config_reg  = cfg_q;
   assign reg_wr_stb  = stb_q;
   assign reg_wr_addr = wr_addr_q;
   assign busy        = ~cs_n_s;

endmodule

// File: tb/tb_bmp280_spi_responder.sv
// Directed bench for bmp280_spi_responder acting as an SPI mode-0 master.
module tb_bmp280_spi_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclk = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        miso, miso_oe, reg_wr_stb, busy;
   logic [19:0] raw_temp = 20'h0;
   logic [15:0] dig_t1 = 16'h0, dig_t2 = 16'h0, dig_t3 = 16'h0;
   logic [7:0]  ctrl_meas, config_reg;
   logic [6:0]  reg_wr_addr;

   int checks = 0;
   int errors = 0;
   int stb_cnt = 0;
   logic [6:0] stb_addr[$];

   always #5 clk = ~clk;

   bmp280_spi_responder #(.DATA_WIDTH_SPI(8), .CHIP_ID(8'h58), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .raw_temp(raw_temp),
      .dig_t1(dig_t1), .dig_t2(dig_t2), .dig_t3(dig_t3),
      .ctrl_meas(ctrl_meas), .config_reg(config_reg), .reg_wr_stb(reg_wr_stb),
      .reg_wr_addr(reg_wr_addr), .busy(busy)
   );

   always @(negedge clk) begin
      if (rst_n && reg_wr_stb) begin
         stb_cnt++;
         stb_addr.push_back(reg_wr_addr);
      end
   end

   // Half sclk period is 8 clk; miso is sampled just before each rising sclk edge.
   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                       output logic oe_any, output logic oe_all);
      rx = 8'h00;
      oe_any = 1'b0;
      oe_all = 1'b1;
      for (int i = 7; i >= 8 - nbits; i--) begin
         mosi = tx[i];
         #80;
         rx[i] = miso;
         oe_any = oe_any | miso_oe;
         oe_all = oe_all & miso_oe;
         sclk = 1'b1;
         #80;
         sclk = 1'b0;
      end
   endtask

   task automatic cs_begin();
      @(negedge clk);
      cs_n = 1'b0;
      #80;
   endtask

   task automatic cs_end();
      #80;
      cs_n = 1'b1;
      #160;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (ctrl_meas !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h expected 00", ctrl_meas); end
      checks++; if (config_reg !== 8'h00) begin errors++; $display("FAIL reset_cfg: got %h expected 00", config_reg); end
      checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", miso_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (reg_wr_stb !== 1'b0 || reg_wr_addr !== 7'h00) begin errors++; $display("FAIL reset_stb: got %b/%h expected 0/00", reg_wr_stb, reg_wr_addr); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_write_burst();
      logic [7:0] rx;
      logic a, b;
      int s0;
      s0 = stb_cnt;
      stb_addr.delete();
      cs_begin();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_active: got %b expected 1", busy); end
      xfer(8'h75, 8, rx, a, b);
      xfer(8'hA6, 8, rx, a, b);
      xfer(8'h74, 8, rx, a, b);
      xfer(8'h27, 8, rx, a, b);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_oe: got %b expected 0", a); end
      cs_end();
      checks++; if (config_reg !== 8'hA4) begin errors++; $display("FAIL wr_cfg: got %h expected a4", config_reg); end
      checks++; if (ctrl_meas !== 8'h27) begin errors++; $display("FAIL wr_ctrl: got %h expected 27", ctrl_meas); end
      checks++; if (stb_cnt - s0 !== 2) begin errors++; $display("FAIL wr_stb_cnt: got %0d expected 2", stb_cnt - s0); end
      if (stb_addr.size() == 2) begin
         checks++; if (stb_addr[0] !== 7'h75) begin errors++; $display("FAIL wr_addr0: got %h expected 75", stb_addr[0]); end
         checks++; if (stb_addr[1] !== 7'h74) begin errors++; $display("FAIL wr_addr1: got %h expected 74", stb_addr[1]); end
      end else begin
         checks++; errors++; $display("FAIL wr_addr_q: got %0d entries expected 2", stb_addr.size());
      end
   endtask

   task automatic test_chip_id();
      logic [7:0] rx;
      logic a, b;
      cs_begin();
      xfer(8'hD0, 8, rx, a, b);
      checks++; if (a !== 1'b0) begin errors++; $display("FAIL id_oe_ctrl: got %b expected 0", a); end
      xfer(8'h00, 8, rx, a, b);
      checks++; if (rx !== 8'h58) begin errors++; $display("FAIL id_byte: got %h expected 58", rx); end
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL id_oe_data: got %b expected 1", b); end
      cs_end();
      checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL id_oe_after: got %b expected 0", miso_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL id_busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_temp_snapshot();
      logic [7:0] r1, r2, r3;
      logic a, b;
      raw_temp = 20'h81234;
      cs_begin();
      xfer(8'hFA, 8, r1, a, b);
      xfer(8'h00, 8, r1, a, b);
      raw_temp = 20'h00000;
      xfer(8'h00, 8, r2, a, b);
      xfer(8'h00, 8, r3, a, b);
      cs_end();
      checks++; if (r1 !== 8'h81) begin errors++; $display("FAIL temp_msb: got %h expected 81", r1); end
      checks++; if (r2 !== 8'h23) begin errors++; $display("FAIL temp_lsb: got %h expected 23", r2); end
      checks++; if (r3 !== 8'h40) begin errors++; $display("FAIL temp_xlsb: got %h expected 40", r3); end
   endtask

   task automatic test_calib_burst();
      logic [7:0] exp_b[6] = '{8'h3A, 8'h6E, 8'h85, 8'h66, 8'h18, 8'hFC};
      logic [7:0] rx;
      logic a, b;
      dig_t1 = 16'h6E3A;
      dig_t2 = 16'h6685;
      dig_t3 = 16'hFC18;
      cs_begin();
      xfer(8'h88, 8, rx, a, b);
      for (int i = 0; i < 6; i++) begin
         xfer(8'h00, 8, rx, a, b);
         checks++; if (rx !== exp_b[i]) begin errors++; $display("FAIL calib_byte%0d: got %h expected %h", i, rx, exp_b[i]); end
      end
      cs_end();
      cs_begin();
      xfer(8'hFF, 8, rx, a, b);
      xfer(8'h00, 8, rx, a, b);
      checks++; if (rx !== 8'h00) begin errors++; $display("FAIL wrap_7f: got %h expected 00", rx); end
      xfer(8'h00, 8, rx, a, b);
      checks++; if (rx !== 8'h00) begin errors++; $display("FAIL wrap_00: got %h expected 00", rx); end
      cs_end();
   endtask

   task automatic test_partial_write();
      logic [7:0] rx;
      logic a, b;
      int s0;
      s0 = stb_cnt;
      cs_begin();
      xfer(8'h74, 8, rx, a, b);
      xfer(8'hFF, 4, rx, a, b);
      cs_end();
      checks++; if (ctrl_meas !== 8'h27) begin errors++; $display("FAIL partial_ctrl: got %h expected 27", ctrl_meas); end
      checks++; if (stb_cnt !== s0) begin errors++; $display("FAIL partial_stb: got %0d expected %0d", stb_cnt, s0); end
      // cs_n rises together with the 8th sclk rise: byte must be dropped
      cs_begin();
      xfer(8'h74, 8, rx, a, b);
      xfer(8'hCC, 7, rx, a, b);
      mosi = 1'b1;
      #80;
      sclk = 1'b1;
      cs_n = 1'b1;
      #80;
      sclk = 1'b0;
      #160;
      checks++; if (ctrl_meas !== 8'h27) begin errors++; $display("FAIL simul_ctrl: got %h expected 27", ctrl_meas); end
      checks++; if (stb_cnt !== s0) begin errors++; $display("FAIL simul_stb: got %0d expected %0d", stb_cnt, s0); end
      cs_begin();
      xfer(8'h74, 8, rx, a, b);
      xfer(8'h55, 8, rx, a, b);
      xfer(8'h10, 8, rx, a, b);
      xfer(8'h99, 8, rx, a, b);
      cs_end();
      checks++; if (ctrl_meas !== 8'h55) begin errors++; $display("FAIL rewrite_ctrl: got %h expected 55", ctrl_meas); end
      checks++; if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL rewrite_stb: got %0d expected 1", stb_cnt - s0); end
      checks++; if (config_reg !== 8'hA4) begin errors++; $display("FAIL rewrite_cfg: got %h expected a4", config_reg); end
   endtask

   task automatic test_soft_reset();
      logic [7:0] rx;
      logic a, b;
      int s0;
      s0 = stb_cnt;
      stb_addr.delete();
      cs_begin();
      xfer(8'h60, 8, rx, a, b);
      xfer(8'hB6, 8, rx, a, b);
      cs_end();
`ifdef BMP_SOFT_RESET_EN
      checks++; if (ctrl_meas !== 8'h00) begin errors++; $display("FAIL srst_ctrl: got %h expected 00", ctrl_meas); end
      checks++; if (config_reg !== 8'h00) begin errors++; $display("FAIL srst_cfg: got %h expected 00", config_reg); end
      checks++; if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL srst_stb: got %0d expected 1", stb_cnt - s0); end
      if (stb_addr.size() > 0) begin
         checks++; if (stb_addr[0] !== 7'h60) begin errors++; $display("FAIL srst_addr: got %h expected 60", stb_addr[0]); end
      end
`else
      checks++; if (ctrl_meas !== 8'h55) begin errors++; $display("FAIL srst_ctrl: got %h expected 55", ctrl_meas); end
      checks++; if (config_reg !== 8'hA4) begin errors++; $display("FAIL srst_cfg: got %h expected a4", config_reg); end
      checks++; if (stb_cnt !== s0) begin errors++; $display("FAIL srst_stb: got %0d expected %0d", stb_cnt, s0); end
`endif
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_chip_id();
      test_temp_snapshot();
      test_calib_burst();
      test_partial_write();
      test_soft_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bmp280_spi_responder.md
Name: bmp280_spi_responder

Overview:
- SPI mode-0 4-wire responder emulating the BMP280 register interface: control byte (bit7 = R/nW, bits6:0 = address), then data bytes.
- Serves the sensor-side end of the transactions our SPI master issues: config and ctrl_meas writes, and temperature and calibration burst reads.
- Used as on-chip sensor model for system simulation and FPGA loopback, and as a register-file front end for a synthetic sensor.
- Oversampled: SPI pins are synchronized into clk.

Parameters:
- DATA_WIDTH_SPI, 8, SPI byte width (fixed at 8; parameterized for consistency).
- CHIP_ID, 8'h58, value returned at address 0x50 (0xD0).
- SYNC_STAGES, 2, flip-flop stages on sclk/cs_n/mosi (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x sclk frequency.
- rst_n  in  1  synchronous active-low reset.
- sclk  in  1  SPI clock from master (idle low).
- cs_n  in  1  SPI chip select, active low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- miso_oe  out  1  MISO output enable; high only during read data bytes.
- raw_temp  in  20  uncompensated temperature source.
- dig_t1, dig_t2, dig_t3  in  16 each  calibration words.
- ctrl_meas  out  8  register 0x74.
- config_reg  out  8  register 0x75.
- reg_wr_stb  out  1  one-clk pulse per accepted register write.
- reg_wr_addr  out  7  address of the last accepted write.
- busy  out  1  high while cs_n (synchronized) is low.

Behaviour:
- Reset (rst_n=0 at a clk edge): ctrl_meas=0x00, config_reg=0x00, miso=0, miso_oe=0, reg_wr_stb=0, reg_wr_addr=0, busy=0, FSM=IDLE.
- Synchronization and edge detection: sclk rise/fall and cs_n fall/rise are detected after SYNC_STAGES+1 clk.
- Sampling and drive: mosi is sampled on a detected sclk rise, MSB first; miso changes only on a detected sclk fall.
- FSM states:
  - IDLE: on cs_n fall, clear the 3-bit bit counter, go to CTRL.
  - CTRL: shift 8 bits. On the 8th rise, latch addr=byte[6:0].
    - byte[7]=1: snapshot raw_temp and dig_t* into shadow registers, preload the shift register with reg(addr), go to RD.
    - byte[7]=0: go to WR.
  - WR: shift 8 bits. On the 8th rise, commit the data to addr and return to CTRL; each write carries its own control byte.
  - RD: miso_oe=1. Bit7 of the preloaded byte is driven on the sclk fall that closes the control byte, then one bit per fall. After the 8th rise, addr increments (0x7F wraps to 0x00) and the next byte is loaded from the shadow/registers.
  - cs_n rise in any state: go to IDLE, miso_oe=0, discard any partial byte (no write, no strobe).
- Read map (7-bit address):
  - 0x08/0x09 = dig_t1[7:0]/[15:8].
  - 0x0A/0x0B = dig_t2 lo/hi.
  - 0x0C/0x0D = dig_t3 lo/hi.
  - 0x50 = CHIP_ID.
  - 0x74 = ctrl_meas.
  - 0x75 = config_reg.
  - 0x7A = raw_temp[19:12].
  - 0x7B = raw_temp[11:4].
  - 0x7C = {raw_temp[3:0], 4'h0}.
  - All other addresses = 0x00.
- Write rules:
  - 0x74 is stored verbatim.
  - 0x75 is stored with bit1 forced to 0 (reserved).
  - Writes to any other address are ignored, with no strobe.
  - On a valid write, reg_wr_stb pulses 1 clk and reg_wr_addr is updated in the same cycle.
- Read consistency: shadow registers hold for the whole burst; input changes are invisible until the next read control byte.
- Simultaneous cs_n rise and 8th sclk rise within the same clk: cs_n wins and the byte is discarded.
- rst_n low mid-transaction: FSM returns to IDLE and registers are reset; the responder stays in IDLE until the next cs_n fall.

Optional Feature:
- Macro BMP_SOFT_RESET_EN.
- Defined: a write of 0xB6 to address 0x60 (0xE0) clears ctrl_meas and config_reg one clk after the commit, and pulses reg_wr_stb with reg_wr_addr=0x60.
- Undefined: 0x60 is an ignored address, like any other unmapped write.

Decomposition:
- Package bmp280_pkg holds:
  - address localparams (CALIB_T1_LSB..CALIB_T3_MSB, CHIP_ID_ADDR, CTRL_MEAS_ADDR, CONFIG_ADDR, TEMP_MSB/LSB/XLSB_ADDR, RESET_ADDR);
  - SOFT_RESET_VAL = 8'hB6;
  - the FSM state encoding (IDLE, CTRL, WR, RD).
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall detect for sclk and cs_n, and delay-matched mosi.

Test Plan:
- Reset: hold rst_n=0 for 3 clk -> ctrl_meas=0x00, config_reg=0x00, miso_oe=0, busy=0.
- Write burst 0x75,0xA6,0x74,0x27 in one CS -> config_reg=0xA4, ctrl_meas=0x27, two reg_wr_stb pulses with reg_wr_addr 0x75 then 0x74.
- Read 0xD0 plus 8 dummy clocks -> miso byte 0x58; miso_oe high only during the data byte.
- raw_temp=20'h81234, read 0xFA plus 24 clocks, raw_temp changed to 20'h00000 after byte 1 -> bytes 0x81, 0x23, 0x40.
- dig_t1=0x6E3A, dig_t2=0x6685, dig_t3=0xFC18, read 0x88 for 6 bytes -> 3A 6E 85 66 18 FC; a burst from 0xFF -> 0x00 then wraps to addr 0x00 -> 0x00.
- Write 0x74 then 4 data bits, cs_n rises -> ctrl_meas unchanged, no strobe. Next write 0x74,0x55 -> ctrl_meas=0x55. With BMP_SOFT_RESET_EN: 0x60,0xB6 -> both registers 0x00.
